// File: rtl/rotator_pipe.sv
// Pipelined barrel rotator/shifter: S = log2(N) stages, each applying a 2^k step.
// Optional out_zero result flag when ROTATOR_PIPE_ZERO_FLAG_EN is defined.

module rotator_stage #(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic [N-1:0] d,
  input  logic [2:0]   mode,
  input  logic         bit_en,
  output logic [N-1:0] q
);
  localparam int DIST = 1 << K;

  always_comb begin
    q = d;
    if (bit_en) begin
      unique case (mode)
        3'b000:  q = {d[N-1-DIST:0], d[N-1:N-DIST]};
        3'b001:  q = {d[DIST-1:0], d[N-1:DIST]};
        3'b010:  q = {d[N-1-DIST:0], {DIST{1'b0}}};
        3'b011:  q = {{DIST{1'b0}}, d[N-1:DIST]};
        3'b100:  q = {{DIST{d[N-1]}}, d[N-1:DIST]};
        default: q = d;
      endcase
    end
  end
endmodule

module rotator_pipe #(
  parameter int N = 8,
  parameter int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_amount,
  input  logic [2:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef ROTATOR_PIPE_ZERO_FLAG_EN
  output logic         out_zero,
`endif
  output logic [N-1:0] out_data
);

  // Index 0 is the unregistered input side; 1..S are stage registers.
  logic [S:0]          vld_pipe;
  logic [S:0][N-1:0]   data_pipe;
  // Control is only needed by stages 0..S-1, so it stops one short of data.
  logic [S-1:0][S-1:0] amt_pipe;
  logic [S-1:0][2:0]   mode_pipe;
  logic [S-1:0][N-1:0] stage_res;
  logic                advance;

  assign advance      = !out_valid || out_ready;
  assign in_ready     = advance;
  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = in_data;
  assign amt_pipe[0]  = in_amount;
  assign mode_pipe[0] = in_mode;

  genvar k;
  generate
    for (k = 0; k < S; k++) begin : g_stage
      rotator_stage #(.N(N), .K(k)) u_stage (
        .d      (data_pipe[k]),
        .mode   (mode_pipe[k]),
        .bit_en (amt_pipe[k][k]),
        .q      (stage_res[k])
      );

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          vld_pipe[k+1]  <= 1'b0;
          data_pipe[k+1] <= '0;
        end else if (advance) begin
          vld_pipe[k+1]  <= vld_pipe[k];
          data_pipe[k+1] <= stage_res[k];
        end
      end

      if (k < S-1) begin : g_ctl
        always_ff @(posedge clk or negedge rstN) begin
          if (!rstN) begin
            amt_pipe[k+1]  <= '0;
            mode_pipe[k+1] <= '0;
          end else if (advance) begin
            amt_pipe[k+1]  <= amt_pipe[k];
            mode_pipe[k+1] <= mode_pipe[k];
          end
        end
      end
    end
  endgenerate

  assign out_valid = vld_pipe[S];
  assign out_data  = data_pipe[S];

`ifdef ROTATOR_PIPE_ZERO_FLAG_EN
  // Registered beside the last data stage so it never adds a path from in_data.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)        out_zero <= 1'b0;
    else if (advance) out_zero <= vld_pipe[S-1] && (stage_res[S-1] == '0);
  end
`endif

endmodule

// File: tb/tb_rotator_pipe.sv
// Directed bench for rotator_pipe (N=8): vector table, stall stream, mid-flight reset.
// Zero-flag checks are compiled in when ROTATOR_PIPE_ZERO_FLAG_EN is defined.

module tb_rotator_pipe;
  localparam int N = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rstN;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_amount;
  logic [2:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
`ifdef ROTATOR_PIPE_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int tests  = 0;
  int failed = 0;

  rotator_pipe #(.N(N)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ROTATOR_PIPE_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    logic [S-1:0] amt;
    logic [2:0]   mode;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Accept one input on the next edge, then check the result after edge S.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = v.data;
    in_amount = v.amt;
    in_mode   = v.mode;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_early"}, 32'(out_valid), 32'd0);
    repeat (S-1) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(v.exp));
`ifdef ROTATOR_PIPE_ZERO_FLAG_EN
    chk({name, "_zero"}, 32'(out_zero), 32'(v.exp == '0));
`endif
  endtask

  function automatic vec_t mk(input logic [N-1:0] d, input logic [S-1:0] a,
                              input logic [2:0] m, input logic [N-1:0] e);
    vec_t v;
    v.data = d; v.amt = a; v.mode = m; v.exp = e;
    return v;
  endfunction

  initial begin
    int sent, recv, cyc;
    logic acc, stall_seen;
    logic [N-1:0] held;

    rstN = 1'b0; in_valid = 1'b0; in_data = '0; in_amount = '0; in_mode = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ROTATOR_PIPE_ZERO_FLAG_EN
    chk("rst_out_zero", 32'(out_zero), 32'd0);
`endif
    rstN = 1'b1;

    vecs.push_back(mk(8'h0F, 3'd4, 3'b000, 8'hF0));
    vecs.push_back(mk(8'hC5, 3'd2, 3'b001, 8'h71));
    vecs.push_back(mk(8'hC5, 3'd2, 3'b000, 8'h17));
    vecs.push_back(mk(8'h80, 3'd7, 3'b100, 8'hFF));
    vecs.push_back(mk(8'h80, 3'd7, 3'b011, 8'h01));
    vecs.push_back(mk(8'h80, 3'd1, 3'b010, 8'h00));
    vecs.push_back(mk(8'hA5, 3'd5, 3'b111, 8'hA5));
    vecs.push_back(mk(8'h3C, 3'd3, 3'b101, 8'h3C));
    vecs.push_back(mk(8'h5A, 3'd7, 3'b110, 8'h5A));
    vecs.push_back(mk(8'hA5, 3'd0, 3'b000, 8'hA5));
    vecs.push_back(mk(8'h96, 3'd0, 3'b100, 8'h96));
    vecs.push_back(mk(8'h81, 3'd3, 3'b000, 8'h0C));
    vecs.push_back(mk(8'h81, 3'd5, 3'b001, 8'h0C));
    vecs.push_back(mk(8'h90, 3'd3, 3'b100, 8'hF2));
    vecs.push_back(mk(8'h0F, 3'd6, 3'b010, 8'hC0));
    vecs.push_back(mk(8'hF0, 3'd5, 3'b011, 8'h07));
    vecs.push_back(mk(8'h70, 3'd6, 3'b100, 8'h01));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stream of 6 with a 5-cycle consumer stall in the middle.
    sent = 0; recv = 0; stall_seen = 1'b0; held = '0;
    for (cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 6);
      in_data   = 8'h01;
      in_amount = 3'(sent);
      in_mode   = 3'b000;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        if (!stall_seen) held = out_data;
        stall_seen = 1'b1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_hold", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream_out%0d", recv), 32'(out_data), 32'(8'h01 << recv));
        recv++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_stall_seen", 32'(stall_seen), 32'd1);
    chk("stream_count", 32'(recv), 32'd6);
    repeat (4) begin
      @(negedge clk);
      chk("stream_no_dup", 32'(out_valid), 32'd0);
    end

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hFF; in_amount = 3'(i); in_mode = 3'b011;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rstN = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("postrst_no_ghost", 32'(out_valid), 32'd0);
    end
    run_vec(mk(8'h01, 3'd1, 3'b000, 8'h02), "postrst_rol");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
